// File: rtl/chip8_pkg.sv
// chip8_pkg: shared constants and state type for the chip8 boot loader.
// Holds the fontset size, top of the 4 KiB address space, default base
// addresses and the loader state enum.
package chip8_pkg;

  localparam int          FONT_BYTES       = 80;
  localparam logic [11:0] MEM_TOP          = 12'hFFF;
  localparam logic [11:0] DEF_FONT_BASE    = 12'h000;
  localparam logic [11:0] DEF_PROGRAM_BASE = 12'h200;

  typedef enum logic [1:0] {
    FONT = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chip8_font_rom.sv
// chip8_font_rom: combinational 80x8 ROM with the standard 0-F 4x5 glyphs,
// five bytes per glyph, glyph 0 first.
// Ports: i_index (7-bit byte index), o_data (glyph byte; 0 for index >= 80).
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] i_index,
  output logic [7:0] o_data
);

  localparam logic [0:FONT_BYTES-1][7:0] FONT_ROM = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

  always_comb begin
    o_data = 8'h00;
    if (i_index < 7'(FONT_BYTES)) begin
      o_data = FONT_ROM[i_index];
    end
  end

endmodule

// File: rtl/chip8_loader.sv
// chip8_loader: boot stage that writes the fontset, then streams a program
// image into memory from PROGRAM_BASE and finally releases the cpu (cpu_run).
// Ports: clk/rst_n; in_valid/in_data/in_last/in_ready program stream;
//   load_start restarts a load from DONE; mem_write/_addr/_data memory port
//   (1-cycle write latency after accept); cpu_run; prog_len, overflow, checksum
//   load status.
// Optional: CHIP8_LOADER_CHECKSUM_EN builds the 16-bit additive checksum;
//   without it checksum is tied to zero.
module chip8_loader
  import chip8_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0] FONT_BASE    = DEF_FONT_BASE,
  parameter logic [ADDR_WIDTH-1:0] PROGRAM_BASE = DEF_PROGRAM_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  load_start,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [7:0]            mem_write_data,
  output logic                  cpu_run,
  output logic [12:0]           prog_len,
  output logic                  overflow,
  output logic [15:0]           checksum
);

  // Write pointer carries one extra bit so addresses past the top of memory
  // are detectable instead of wrapping into the fontset.
  localparam int PW = ADDR_WIDTH + 1;

  state_t                r_state;
  logic [6:0]            r_font_idx;
  logic [PW-1:0]         r_ptr;
  logic                  r_in_ready;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_data;
  logic                  r_cpu_run;
  logic [12:0]           r_prog_len;
  logic                  r_overflow;

  logic [7:0]            w_font_byte;
  logic                  w_accept;
  logic                  w_restart;
  logic                  w_oob;

  chip8_font_rom u_font_rom (
    .i_index (r_font_idx),
    .o_data  (w_font_byte)
  );

  assign w_accept  = (r_state == LOAD) && in_valid && r_in_ready;
  assign w_restart = (r_state == DONE) && load_start;
  assign w_oob     = r_ptr[ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FONT;
      r_font_idx  <= '0;
      r_ptr       <= {1'b0, PROGRAM_BASE};
      r_in_ready  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cpu_run   <= 1'b0;
      r_prog_len  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        FONT: begin
          // Index FONT_BYTES is a spare cycle: the last font write is on the
          // bus while in_ready is still low, so the stream opens one cycle later.
          if (r_font_idx == 7'(FONT_BYTES)) begin
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
          end else begin
            r_mem_write <= 1'b1;
            r_addr      <= FONT_BASE + ADDR_WIDTH'(r_font_idx);
            r_data      <= w_font_byte;
            r_font_idx  <= r_font_idx + 7'd1;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_addr <= r_ptr[ADDR_WIDTH-1:0];
            r_data <= in_data;
            // Bytes past the top of memory are consumed but never written;
            // the pointer parks there so it cannot wrap.
            if (w_oob) begin
              r_overflow <= 1'b1;
            end else begin
              r_mem_write <= 1'b1;
              r_ptr       <= r_ptr + PW'(1);
            end
            if (r_prog_len != 13'h1FFF) begin
              r_prog_len <= r_prog_len + 13'd1;
            end
            if (in_last) begin
              r_state    <= DONE;
              r_in_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          if (w_restart) begin
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
            r_cpu_run  <= 1'b0;
            r_ptr      <= {1'b0, PROGRAM_BASE};
            r_prog_len <= '0;
            r_overflow <= 1'b0;
          end else begin
            // Raised one cycle after entering DONE so it never overlaps
            // the final program write.
            r_cpu_run <= 1'b1;
          end
        end
        default: begin
          r_state <= FONT;
        end
      endcase
    end
  end

`ifdef CHIP8_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_restart) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + {8'h00, in_data};
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 16'h0000;
`endif

  assign in_ready       = r_in_ready;
  assign mem_write      = r_mem_write;
  assign mem_write_addr = r_addr;
  assign mem_write_data = r_data;
  assign cpu_run        = r_cpu_run;
  assign prog_len       = r_prog_len;
  assign overflow       = r_overflow;

endmodule
